obstacle_avoid_ctrl: RTL and testbench



---
 rtl/obstacle_avoid_pkg.sv | 37 +++
 rtl/obstacle_avoid_ctrl_if.sv | 20 ++
 rtl/dwell_timer.sv | 29 ++
 rtl/obstacle_avoid_ctrl.sv | 119 +++++++++++
 tb/tb_obstacle_avoid_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/obstacle_avoid_pkg.sv
// Shared types for the obstacle-avoidance controller: state codes, motor command
// encodings and the state-to-wheel-command decode.
package obstacle_avoid_pkg;

    typedef enum logic [2:0] {
        S_STOP   = 3'd0,
        S_FWD    = 3'd1,
        S_REV    = 3'd2,
        S_TURN_L = 3'd3,
        S_TURN_R = 3'd4
    } state_t;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_REV  = 2'b10;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
    } motor_t;

    // A pivot turns toward the named side by running that wheel backwards.
    function automatic motor_t motor_cmd(input state_t s);
        motor_t m;
        m.left  = MOT_STOP;
        m.right = MOT_STOP;
        case (s)
            S_FWD:    begin m.left = MOT_FWD; m.right = MOT_FWD; end
            S_REV:    begin m.left = MOT_REV; m.right = MOT_REV; end
            S_TURN_L: begin m.left = MOT_REV; m.right = MOT_FWD; end
            S_TURN_R: begin m.left = MOT_FWD; m.right = MOT_REV; end
            default:  ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/obstacle_avoid_ctrl_if.sv
// Detector-to-controller link: level detection flags in, wheel commands and status out.
interface obstacle_avoid_ctrl_if;
    logic       left_object_detected;
    logic       right_object_detected;
    logic       front_object_detected;
    logic [1:0] motor_left;
    logic [1:0] motor_right;
    logic [2:0] state_o;
    logic [7:0] avoid_count;

    modport master (
        output left_object_detected, right_object_detected, front_object_detected,
        input  motor_left, motor_right, state_o, avoid_count
    );

    modport slave (
        input  left_object_detected, right_object_detected, front_object_detected,
        output motor_left, motor_right, state_o, avoid_count
    );
endinterface

// File: rtl/dwell_timer.sv
// Up-counter timing how long the controller has sat in its current state.
// Latency: done is combinational from the count; count updates on clk.
// Backpressure: none; clr has priority over en, done only asserts while enabled.
module dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = en && (cnt == term);

endmodule

// File: rtl/obstacle_avoid_ctrl.sv
// Moore FSM turning left/right/front detection flags into differential wheel commands.
// Latency: one clock from flag sample to registered motor/state outputs.
// Backpressure: none; flags are levels, ignored while a stop/reverse/turn dwell runs.
module obstacle_avoid_ctrl
    import obstacle_avoid_pkg::*;
#(
    parameter int STOP_CYCLES = 4,
    parameter int REV_CYCLES  = 8,
    parameter int TURN_CYCLES = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    obstacle_avoid_ctrl_if.slave bus
);

    localparam int MAX_SR    = (STOP_CYCLES > REV_CYCLES) ? STOP_CYCLES : REV_CYCLES;
    localparam int MAX_DWELL = (MAX_SR > TURN_CYCLES) ? MAX_SR : TURN_CYCLES;
    localparam int TW        = $clog2(MAX_DWELL) + 1;

    state_t        state;
    state_t        state_nxt;
    state_t        pref_turn;
    logic          turn_pref;
    logic          pref_toggle;
    logic          timed;
    logic          done;
    logic          entering;
    logic          turn_entry;
    logic [TW-1:0] term;
    motor_t        motor_q;
    logic [7:0]    avoid_cnt_q;
    logic          left_det;
    logic          right_det;
    logic          front_det;

    assign left_det  = bus.left_object_detected;
    assign right_det = bus.right_object_detected;
    assign front_det = bus.front_object_detected;

    always_comb begin
        timed = 1'b1;
        term  = '0;
        case (state)
            S_STOP:             term = TW'(STOP_CYCLES - 1);
            S_REV:              term = TW'(REV_CYCLES - 1);
            S_TURN_L, S_TURN_R: term = TW'(TURN_CYCLES - 1);
            default:            timed = 1'b0;
        endcase
    end

    // Every state change restarts the dwell count; timed states never self-loop.
    dwell_timer #(.W(TW)) u_dwell_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (entering),
        .en    (timed),
        .term  (term),
        .done  (done)
    );

    assign pref_turn = turn_pref ? S_TURN_R : S_TURN_L;

    always_comb begin
        state_nxt   = state;
        pref_toggle = 1'b0;
        case (state)
            S_FWD: begin
                if (front_det)                     state_nxt = S_STOP;
                else if (left_det && !right_det)   state_nxt = S_TURN_R;
                else if (right_det && !left_det)   state_nxt = S_TURN_L;
            end
            S_STOP: begin
                if (done) begin
                    if (!front_det)                   state_nxt = S_FWD;
                    else if (left_det && right_det)   state_nxt = S_REV;
                    else if (left_det)                state_nxt = S_TURN_R;
                    else if (right_det)               state_nxt = S_TURN_L;
                    else begin
                        state_nxt   = pref_turn;
                        pref_toggle = 1'b1;
                    end
                end
            end
            S_REV: begin
                if (done) begin
                    state_nxt   = pref_turn;
                    pref_toggle = 1'b1;
                end
            end
            S_TURN_L, S_TURN_R: begin
                if (done) state_nxt = front_det ? S_STOP : S_FWD;
            end
            default: state_nxt = S_STOP;
        endcase
    end

    assign entering   = (state_nxt != state);
    assign turn_entry = entering && ((state_nxt == S_TURN_L) || (state_nxt == S_TURN_R));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_STOP;
            turn_pref   <= 1'b0;
            motor_q     <= '0;
            avoid_cnt_q <= '0;
        end else begin
            state   <= state_nxt;
            motor_q <= motor_cmd(state_nxt);
            if (pref_toggle) turn_pref <= ~turn_pref;
            if (turn_entry && (avoid_cnt_q != 8'hFF)) avoid_cnt_q <= avoid_cnt_q + 8'd1;
        end
    end

    assign bus.motor_left  = motor_q.left;
    assign bus.motor_right = motor_q.right;
    assign bus.state_o     = state;
    assign bus.avoid_count = avoid_cnt_q;

endmodule

// File: tb/tb_obstacle_avoid_ctrl.sv
// Directed table-driven bench for obstacle_avoid_ctrl plus hand-written reset and
// saturation sequences.
module tb_obstacle_avoid_ctrl;

    typedef struct {
        logic [2:0] lrf;
        logic [1:0] ml;
        logic [1:0] mr;
        logic [2:0] st;
        logic [7:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    obstacle_avoid_ctrl_if bus();

    obstacle_avoid_ctrl #(
        .STOP_CYCLES (4),
        .REV_CYCLES  (8),
        .TURN_CYCLES (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] ml, input logic [1:0] mr,
                             input logic [2:0] st, input logic [7:0] cnt);
        check({name, "_motor"}, {4'b0, bus.motor_left, bus.motor_right}, {4'b0, ml, mr});
        check({name, "_state"}, {5'b0, bus.state_o}, {5'b0, st});
        check({name, "_count"}, bus.avoid_count, cnt);
    endtask

    task automatic add(input logic [2:0] lrf, input logic [1:0] ml, input logic [1:0] mr,
                       input logic [2:0] st, input logic [7:0] cnt, input int n);
        vec_t v;
        v.lrf = lrf; v.ml = ml; v.mr = mr; v.st = st; v.cnt = cnt;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    // Drive flags {left,right,front}, take one rising edge, settle just after it.
    task automatic step(input logic [2:0] lrf);
        bus.left_object_detected  = lrf[2];
        bus.right_object_detected = lrf[1];
        bus.front_object_detected = lrf[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_cnt;

        // After reset: STOP dwell then forward.
        add(3'b000, 2'b00, 2'b00, 3'd0, 8'd0, 3);
        add(3'b000, 2'b01, 2'b01, 3'd1, 8'd0, 2);
        // Left pulse: pivot right for six cycles.
        add(3'b100, 2'b01, 2'b10, 3'd4, 8'd1, 1);
        add(3'b000, 2'b01, 2'b10, 3'd4, 8'd1, 5);
        add(3'b000, 2'b01, 2'b01, 3'd1, 8'd1, 1);
        // Front held: stop, turn left (pref 0), stop again, turn right (pref 1).
        add(3'b001, 2'b00, 2'b00, 3'd0, 8'd1, 4);
        add(3'b001, 2'b10, 2'b01, 3'd3, 8'd2, 6);
        add(3'b001, 2'b00, 2'b00, 3'd0, 8'd2, 4);
        add(3'b001, 2'b01, 2'b10, 3'd4, 8'd3, 1);
        add(3'b000, 2'b01, 2'b10, 3'd4, 8'd3, 5);
        add(3'b000, 2'b01, 2'b01, 3'd1, 8'd3, 1);
        // All three flags: stop, reverse eight cycles regardless of flags, turn left.
        add(3'b111, 2'b00, 2'b00, 3'd0, 8'd3, 4);
        add(3'b111, 2'b10, 2'b10, 3'd2, 8'd3, 1);
        add(3'b000, 2'b10, 2'b10, 3'd2, 8'd3, 2);
        add(3'b100, 2'b10, 2'b10, 3'd2, 8'd3, 2);
        add(3'b011, 2'b10, 2'b10, 3'd2, 8'd3, 3);
        add(3'b111, 2'b10, 2'b01, 3'd3, 8'd4, 1);
        add(3'b000, 2'b10, 2'b01, 3'd3, 8'd4, 5);
        add(3'b000, 2'b01, 2'b01, 3'd1, 8'd4, 1);
        // Left+right without front keeps driving; right only pivots left.
        add(3'b110, 2'b01, 2'b01, 3'd1, 8'd4, 2);
        add(3'b010, 2'b10, 2'b01, 3'd3, 8'd5, 1);
        add(3'b000, 2'b10, 2'b01, 3'd3, 8'd5, 5);
        add(3'b000, 2'b01, 2'b01, 3'd1, 8'd5, 1);

        bus.left_object_detected  = 1'b0;
        bus.right_object_detected = 1'b0;
        bus.front_object_detected = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check_out("reset", 2'b00, 2'b00, 3'd0, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].lrf);
            check_out($sformatf("vec%0d", i), tbl[i].ml, tbl[i].mr, tbl[i].st, tbl[i].cnt);
        end

        // Reset mid-turn (timer at 3) must clear outputs with no clock edge.
        step(3'b100);
        check_out("midturn_entry", 2'b01, 2'b10, 3'd4, 8'd6);
        repeat (3) step(3'b000);
        #3 reset = 1'b1;
        #1;
        check_out("async_reset", 2'b00, 2'b00, 3'd0, 8'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) step(3'b000);
        check_out("rst_stop", 2'b00, 2'b00, 3'd0, 8'd0);
        step(3'b000);
        check_out("rst_fwd", 2'b01, 2'b01, 3'd1, 8'd0);
        // turn_pref was 1 before reset; front-only must now pick a left pivot.
        repeat (4) step(3'b001);
        check_out("rst_front_stop", 2'b00, 2'b00, 3'd0, 8'd0);
        step(3'b001);
        check_out("rst_pref_left", 2'b10, 2'b01, 3'd3, 8'd1);
        repeat (6) step(3'b000);
        check_out("rst_turn_done", 2'b01, 2'b01, 3'd1, 8'd1);

        // Saturation of the turn counter.
        exp_cnt = 8'd1;
        for (int t = 0; t < 260; t++) begin
            step(3'b100);
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            repeat (6) step(3'b000);
            check($sformatf("sat_turn%0d", t), bus.avoid_count, exp_cnt);
        end
        check_out("sat_final", 2'b01, 2'b01, 3'd1, 8'd255);
        repeat (3) step(3'b110);
        check_out("sat_lr_hold", 2'b01, 2'b01, 3'd1, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
